sram_controller: RTL and testbench

//   Bridges the MEM stage's 32-bit data-memory port to the board's 16-bit asynchronous SRAM.

---
 rtl/sram_controller_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 23 ++
 rtl/sram_controller.sv | 143 ++++++++++++++
 tb/tb_sram_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit to 16-bit async SRAM bridge.
// Carries SRAM bus widths and the controller state encoding.
package sram_controller_pkg;

  localparam int SRAM_DATA_LEN = 16;
  localparam int SRAM_ADDR_LEN = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for one SRAM half-word phase.
// last is high on the final cycle of a WAIT_CYCLES-long phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else              count <= count + CW'(1);
  end

  assign last = (count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data port to 16-bit async SRAM, two half-word cycles per word.
// Define SRAM_ADDR_CHECK_EN to reject misaligned / out-of-range addresses.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_ADDR_W = SRAM_ADDR_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  output logic                     addr_error,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  localparam int WW = SRAM_ADDR_W - 1;

  sram_state_e             state;
  logic                    is_wr;
  logic [WW-1:0]           word_q;
  logic [15:0]             wdata_hi_q;
  logic [15:0]             lo_q;
  logic [15:0]             dq_out;
  logic                    dq_oe;
  logic                    we_n_q;
  logic                    err_q;
  logic                    last;
  logic                    clear;
  logic                    req;
  logic                    bad;
  logic [31:0]             off;
  logic [WW-1:0]           word;
  logic                    unused_bits;

  assign req  = rd_en | wr_en;
  assign off  = address - 32'(ADDR_BASE);
  assign word = off[SRAM_ADDR_W:2];
  assign unused_bits = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
  assign bad = (address < 32'(ADDR_BASE)) ||
               (address[1:0] != 2'b00) ||
               (off[31:SRAM_ADDR_W+1] != '0);
`else
  assign bad = 1'b0;
`endif

  assign clear = (state == IDLE) || (state == DONE) || last;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .last (last)
  );

  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_wr      <= 1'b0;
      word_q     <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      we_n_q     <= 1'b1;
      err_q      <= 1'b0;
      read_data  <= '0;
      SRAM_OE_N  <= 1'b1;
      SRAM_ADDR  <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: if (req) begin
          is_wr      <= wr_en;
          word_q     <= word;
          wdata_hi_q <= write_data[31:16];
          if (bad) begin
            state <= DONE;
            err_q <= 1'b1;
            if (!wr_en) read_data <= '0;
          end else begin
            state     <= LO;
            SRAM_ADDR <= {word, 1'b0};
            if (wr_en) begin
              we_n_q <= 1'b0;
              dq_oe  <= 1'b1;
              dq_out <= write_data[15:0];
            end else begin
              SRAM_OE_N <= 1'b0;
            end
          end
        end
        LO: if (last) begin
          state     <= HI;
          SRAM_ADDR <= {word_q, 1'b1};
          if (is_wr) dq_out <= wdata_hi_q;
          else       lo_q   <= SRAM_DQ;
        end
        HI: if (last) begin
          state     <= DONE;
          we_n_q    <= 1'b1;
          dq_oe     <= 1'b0;
          SRAM_OE_N <= 1'b1;
          if (!is_wr) read_data <= {SRAM_DQ, lo_q};
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  // WE_N rises on the last phase cycle while DQ and address stay put
  assign SRAM_WE_N  = we_n_q | last;
  assign SRAM_DQ    = dq_oe ? dq_out : 'z;
  assign addr_error = err_q;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural SRAM.
// Word-level reference model checks loads, stores and SRAM contents.
module tb_sram_controller;

  localparam int WAIT = 5;
  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int LAT  = 2 * WAIT + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready, addr_error;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         we_n, oe_n, ce_n, ub_n, lb_n;

  always #5 clk = ~clk;

  sram_controller #(
    .WAIT_CYCLES(WAIT),
    .ADDR_BASE  (BASE),
    .SRAM_ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .addr_error(addr_error),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  logic [15:0] mem [0:(1<<AW)-1];
  logic        park;
  logic [15:0] park_val;

  assign sram_dq = (!oe_n && we_n) ? mem[sram_addr] :
                   (park ? park_val : 16'bz);

  always @(negedge clk)
    if (!ce_n && !we_n) mem[sram_addr] <= sram_dq;

  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd;
  int          checks = 0;
  int          passes = 0;

  task automatic access(input bit wr, input bit rd,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat,
                        output logic err, output logic [15:0] oe_mask,
                        output int we_cnt, output logic r0);
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1;
    r0 = ready;
    lat = -1; rdat = '0; err = 1'b0; oe_mask = '0; we_cnt = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (!oe_n && k < 16) oe_mask[k] = 1'b1;
      if (!we_n) we_cnt++;
      if (ready) begin
        lat = k; rdat = read_data; err = addr_error;
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 0; rd_en = 0; address = '0; write_data = '0;
    park = 1'b0; park_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (read_data !== 32'h0) $display("FAIL rst_read_data got %h want 0", read_data); else passes++;
    checks++; if (addr_error !== 1'b0) $display("FAIL rst_addr_error got %b want 0", addr_error); else passes++;
    checks++; if ({we_n, oe_n} !== 2'b11) $display("FAIL rst_strobes got %b want 11", {we_n, oe_n}); else passes++;
    checks++; if (sram_addr !== 18'h0) $display("FAIL rst_sram_addr got %h want 0", sram_addr); else passes++;
    checks++; if (ready !== 1'b1) $display("FAIL rst_ready got %b want 1", ready); else passes++;
    checks++; if ({ce_n, ub_n, lb_n} !== 3'b000) $display("FAIL rst_tied got %b want 000", {ce_n, ub_n, lb_n}); else passes++;
    park = 1'b1; park_val = 16'hC3C3; #1;
    checks++; if (sram_dq !== 16'hC3C3) $display("FAIL rst_dq_release got %h want c3c3", sram_dq); else passes++;
    park = 1'b0;
    rst = 1'b0;
    exp_rd = '0;
  endtask

  task automatic test_store();
    int lat, wc; logic [31:0] rd; logic er; logic [15:0] om; logic r0;
    access(1, 0, 32'd1024, 32'h12345678, lat, rd, er, om, wc, r0);
    ref_mem[0] = 32'h12345678;
    checks++; if (r0 !== 1'b0) $display("FAIL st_ready_c0 got %b want 0", r0); else passes++;
    checks++; if (lat != LAT) $display("FAIL st_latency got %0d want %0d", lat, LAT); else passes++;
    checks++; if (mem[0] !== 16'h5678) $display("FAIL st_sram0 got %h want 5678", mem[0]); else passes++;
    checks++; if (mem[1] !== 16'h1234) $display("FAIL st_sram1 got %h want 1234", mem[1]); else passes++;
    checks++; if (wc != 2 * (WAIT - 1)) $display("FAIL st_we_cycles got %0d want %0d", wc, 2 * (WAIT - 1)); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL st_addr_error got %b want 0", er); else passes++;
  endtask

  task automatic test_load();
    int lat, wc; logic [31:0] rd; logic er; logic [15:0] om; logic r0;
    logic [15:0] want_mask;
    want_mask = '0;
    for (int k = 1; k <= 2 * WAIT; k++) want_mask[k] = 1'b1;
    access(0, 1, 32'd1024, 32'h0, lat, rd, er, om, wc, r0);
    exp_rd = ref_mem[0];
    checks++; if (lat != LAT) $display("FAIL ld_latency got %0d want %0d", lat, LAT); else passes++;
    checks++; if (rd !== exp_rd) $display("FAIL ld_data got %h want %h", rd, exp_rd); else passes++;
    checks++; if (om !== want_mask) $display("FAIL ld_oe_cycles got %h want %h", om, want_mask); else passes++;
    checks++; if (wc != 0) $display("FAIL ld_we_cycles got %0d want 0", wc); else passes++;
  endtask

  task automatic test_back_to_back();
    int highs, first, second;
    logic [31:0] d, rd;
    d = $urandom;
    highs = 0; first = -1; second = -1; rd = '0;
    @(negedge clk);
    wr_en = 1; rd_en = 0; address = 32'd1028; write_data = d;
    for (int k = 1; k <= 60 && second < 0; k++) begin
      @(negedge clk);
      if (ready) begin
        highs++;
        if (first < 0) begin
          first = k; wr_en = 0; rd_en = 1;
        end else begin
          second = k; rd = read_data;
        end
      end
    end
    wr_en = 0; rd_en = 0;
    ref_mem[1] = d;
    exp_rd = d;
    checks++; if (first != LAT) $display("FAIL b2b_first got %0d want %0d", first, LAT); else passes++;
    checks++; if (second != 2 * LAT + 1) $display("FAIL b2b_second got %0d want %0d", second, 2 * LAT + 1); else passes++;
    checks++; if (highs != 2) $display("FAIL b2b_ready_highs got %0d want 2", highs); else passes++;
    checks++; if (rd !== d) $display("FAIL b2b_data got %h want %h", rd, d); else passes++;
  endtask

  task automatic test_rd_wr_both();
    int lat, wc; logic [31:0] rd; logic er; logic [15:0] om; logic r0;
    access(1, 1, 32'd1032, 32'hCAFEF00D, lat, rd, er, om, wc, r0);
    ref_mem[2] = 32'hCAFEF00D;
    checks++; if (lat != LAT) $display("FAIL both_latency got %0d want %0d", lat, LAT); else passes++;
    checks++; if ({mem[5], mem[4]} !== 32'hCAFEF00D) $display("FAIL both_sram got %h want cafef00d", {mem[5], mem[4]}); else passes++;
    checks++; if (rd !== exp_rd) $display("FAIL both_read_data got %h want %h", rd, exp_rd); else passes++;
    checks++; if (om !== 16'h0) $display("FAIL both_oe got %h want 0", om); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    wr_en = 1; rd_en = 0; address = 32'd1060; write_data = 32'h7E5A_5A7E;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({we_n, oe_n} !== 2'b11) $display("FAIL rmid_strobes got %b want 11", {we_n, oe_n}); else passes++;
    checks++; if (sram_addr !== 18'h0) $display("FAIL rmid_sram_addr got %h want 0", sram_addr); else passes++;
    park = 1'b1; park_val = 16'hC3C3; #1;
    checks++; if (sram_dq !== 16'hC3C3) $display("FAIL rmid_dq_a got %h want c3c3", sram_dq); else passes++;
    park_val = 16'h3C3C; #1;
    checks++; if (sram_dq !== 16'h3C3C) $display("FAIL rmid_dq_b got %h want 3c3c", sram_dq); else passes++;
    park = 1'b0;
    rst = 1'b0; wr_en = 0;
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", ready); else passes++;
    ref_mem.delete(9);
  endtask

  task automatic test_random();
    int lat, wc, w; logic [31:0] rd, d, a; logic er; logic [15:0] om; logic r0;
    for (int i = 0; i < 24; i++) begin
      w = int'($urandom_range(0, 31));
      a = 32'(BASE + 4 * w);
      if (ref_mem.exists(w) && $urandom_range(0, 1) == 1) begin
        access(0, 1, a, 32'h0, lat, rd, er, om, wc, r0);
        exp_rd = ref_mem[w];
        checks++; if (rd !== exp_rd || lat != LAT) $display("FAIL rnd_load w%0d got %h/%0d want %h/%0d", w, rd, lat, exp_rd, LAT); else passes++;
      end else begin
        d = $urandom;
        access(1, 0, a, d, lat, rd, er, om, wc, r0);
        ref_mem[w] = d;
        checks++; if ({mem[2*w+1], mem[2*w]} !== d || lat != LAT) $display("FAIL rnd_store w%0d got %h/%0d want %h/%0d", w, {mem[2*w+1], mem[2*w]}, lat, d, LAT); else passes++;
      end
    end
  endtask

  task automatic test_addr_check();
`ifdef SRAM_ADDR_CHECK_EN
    int lat, wc; logic [31:0] rd, a; logic er; logic [15:0] om; logic r0;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 32'd1000 : 32'd1026;
      access(0, 1, a, 32'h0, lat, rd, er, om, wc, r0);
      checks++; if (lat != 1) $display("FAIL chk_latency @%0d got %0d want 1", a, lat); else passes++;
      checks++; if (er !== 1'b1) $display("FAIL chk_error @%0d got %b want 1", a, er); else passes++;
      checks++; if (rd !== 32'h0) $display("FAIL chk_data @%0d got %h want 0", a, rd); else passes++;
      checks++; if (om !== 16'h0 || wc != 0) $display("FAIL chk_strobes @%0d got %h/%0d want 0/0", a, om, wc); else passes++;
      exp_rd = '0;
    end
`else
    int lat, wc; logic [31:0] rd; logic er; logic [15:0] om; logic r0;
    access(0, 1, 32'd1024, 32'h0, lat, rd, er, om, wc, r0);
    checks++; if (er !== 1'b0) $display("FAIL nochk_error got %b want 0", er); else passes++;
    checks++; if (rd !== ref_mem[0]) $display("FAIL nochk_data got %h want %h", rd, ref_mem[0]); else passes++;
`endif
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_rd_wr_both();
    test_reset_mid();
    test_random();
    test_addr_check();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
